pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
Supervises the fabric PLL from the 50 MHz reference clock domain. It drives the PLL reset and consumes the PLL locked flag, which is asynchronous. It releases the system reset only after lock has been stable for a programmable time. It re-sequences the PLL after a lock timeout or a loss of lock, and enters a sticky fault state after too many failed attempts. It sits between board reset and the PLL wrapper, and gates the reset of all logic clocked by the PLL output.

Parameters:
RST_HOLD_CYCLES, 16, refclk cycles pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT, 50000, refclk cycles allowed in WAIT_LOCK before the attempt fails (1 ms at 50 MHz)
LOCK_STABLE_CYCLES, 1024, consecutive refclk cycles locked must stay high before release
MAX_RETRIES, 3, failed attempts tolerated before FAULT (>=1)
CNT_W, 20, shared cycle-counter width; must hold max(RST_HOLD_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES)
RETRY_W, 4, retry counter width; must hold MAX_RETRIES

Ports:
refclk  in  1  50 MHz reference clock; the only clock
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL locked flag, asynchronous to refclk
pll_rst  out  1  reset to the PLL; high = PLL held in reset
sys_rst  out  1  reset for downstream logic, active-high
ready  out  1  high while the PLL is locked and released
fault  out  1  sticky; high when retries are exhausted
lock_lost  out  1  one-cycle pulse on loss of lock while in RUN
retry_count  out  RETRY_W  failed attempts since the last successful RUN entry

Behaviour:
- Clock and reset: one clock (refclk). Reset rst is synchronous and active-high; it is sampled on the refclk rising edge.
- Synchronizer: pll_locked passes through a 2-flop synchronizer to give locked_s. The synchronizer flops reset to 0.
- Outputs are Moore-decoded from the state register, except lock_lost, which is a registered pulse:
  - pll_rst = (HOLD or FAULT)
  - ready = RUN
  - sys_rst = !RUN
  - fault = FAULT
- Reset values: state HOLD, counter 0, retry_count 0. Hence pll_rst=1, sys_rst=1, ready=0, fault=0, lock_lost=0.
- rst mid-operation, from any state including FAULT: the next edge returns everything to the reset values.
- HOLD: counter increments each cycle. When counter == RST_HOLD_CYCLES-1, go to WAIT_LOCK and clear counter. HOLD therefore lasts exactly RST_HOLD_CYCLES cycles.
- WAIT_LOCK: pll_rst=0.
  - If locked_s=1: go to STABLE, counter cleared.
  - Else if counter == LOCK_TIMEOUT-1: retry_count+1. If the new value == MAX_RETRIES, go to FAULT; otherwise go to HOLD. Counter cleared.
  - Otherwise: counter increments.
- STABLE:
  - If locked_s=0: go to WAIT_LOCK, counter cleared, no retry increment. The timeout restarts.
  - Else if counter == LOCK_STABLE_CYCLES-1: go to RUN and clear retry_count.
  - Otherwise: counter increments.
- RUN: if locked_s=0, go to HOLD with counter cleared, and lock_lost=1 for exactly one cycle, coincident with the first HOLD cycle. retry_count is not incremented. sys_rst reasserts in that same cycle.
- FAULT: terminal until rst. pll_rst=1, sys_rst=1, retry_count frozen at MAX_RETRIES.
- Latency: with pll_locked rising before edge 0 and stable thereafter, ready first reads 1 after edge LOCK_STABLE_CYCLES+2. Asynchronous sampling may add one cycle.
- Simultaneous events:
  - In WAIT_LOCK, locked_s=1 on the timeout cycle: lock wins, go to STABLE.
  - In STABLE, locked_s=0 on the final count cycle: the drop wins, go to WAIT_LOCK.
- The counter never wraps: every transition clears it, and no state counts past its limit.

Test Plan:
Parameter overrides for all directed tests: RST_HOLD_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- Reset then nominal lock: rst high for 3 edges, then low. Model drives pll_locked=1 ten cycles after pll_rst falls.
  -> pll_rst high for exactly 4 cycles after rst release.
  -> ready=1 and sys_rst=0 after edge 10 counted from locked rise.
  -> retry_count=0, fault=0.
- No lock ever: pll_locked held 0.
  -> pll_rst pulses 4 cycles, then 32 cycles low; retry_count=1.
  -> Second pulse, then 32 low; fault=1, pll_rst=1, retry_count=2, sys_rst stays 1 throughout.
- Glitchy lock: locked high for 5 cycles, low for 1, then high.
  -> STABLE aborts, re-enters from WAIT_LOCK.
  -> ready rises 8+ cycles after the final rise; retry_count unchanged.
- Loss of lock in RUN: drop pll_locked after ready=1.
  -> Within 3 edges: lock_lost is a single 1-cycle pulse, sys_rst=1, ready=0, pll_rst=1 for 4 cycles.
  -> Relock -> RUN again.
- rst during FAULT and during STABLE: assert rst for 1 edge.
  -> Next cycle all outputs at reset values, retry_count=0.
- Boundary: lock arrives exactly on cycle 31 of WAIT_LOCK.
  -> STABLE entered, no retry increment, no HOLD pulse.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: holds the PLL in reset, waits for a stable lock,
// releases system reset, and retries or faults when lock is not achieved.
module pll_lock_supervisor #(
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 3,
  parameter int CNT_W              = 20,
  parameter int RETRY_W            = 4
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fault,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count
);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX =
    RETRY_W'(MAX_RETRIES);

  logic               r_sync1;
  logic               r_sync2;
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [RETRY_W-1:0] r_retry;
  logic               r_pll_rst;
  logic               r_sys_rst;
  logic               r_ready;
  logic               r_fault;
  logic               r_lock_lost;

  logic               w_locked_s;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [RETRY_W-1:0] w_retry_nxt;
  logic [RETRY_W-1:0] w_retry_inc;
  logic               w_lost;

  // pll_locked is asynchronous to refclk
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  assign w_locked_s  = r_sync2;
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_retry_inc = r_retry + 1'b1;
  assign w_lost      = (r_state == S_RUN) && !w_locked_s;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    unique case (r_state)
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_WAIT: begin
        if (w_locked_s) begin
          w_state_nxt = S_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TO_LAST) begin
          w_retry_nxt = w_retry_inc;
          w_cnt_nxt   = '0;
          if (w_retry_inc == RETRY_MAX) begin
            w_state_nxt = S_FAULT;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_STABLE: begin
        // a drop restarts the timeout without costing a retry
        if (!w_locked_s) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STB_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
          w_retry_nxt = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_RUN: begin
        if (!w_locked_s) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: begin
        w_state_nxt = S_HOLD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= S_HOLD;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      r_pll_rst   <= (w_state_nxt == S_HOLD) ||
                     (w_state_nxt == S_FAULT);
      r_sys_rst   <= (w_state_nxt != S_RUN);
      r_ready     <= (w_state_nxt == S_RUN);
      r_fault     <= (w_state_nxt == S_FAULT);
      r_lock_lost <= w_lost;
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_rst     = r_sys_rst;
  assign ready       = r_ready;
  assign fault       = r_fault;
  assign lock_lost   = r_lock_lost;
  assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: every output change is
// matched against a queued {cycle, output vector} expectation.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [3:0] retry_count;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int         cyc;
    logic [8:0] vec;
    string      name;
  } exp_t;

  exp_t q[$];

  // vector = {pll_rst, sys_rst, ready, fault, lock_lost, retry_count}
  localparam logic [8:0] V_R  = 9'b1_1_0_0_0_0000;
  localparam logic [8:0] V_W  = 9'b0_1_0_0_0_0000;
  localparam logic [8:0] V_U  = 9'b0_0_1_0_0_0000;
  localparam logic [8:0] V_L  = 9'b1_1_0_0_1_0000;
  localparam logic [8:0] V_H1 = 9'b1_1_0_0_0_0001;
  localparam logic [8:0] V_W1 = 9'b0_1_0_0_0_0001;
  localparam logic [8:0] V_F  = 9'b1_1_0_1_0_0010;

  pll_lock_supervisor #(
    .RST_HOLD_CYCLES   (4),
    .LOCK_TIMEOUT      (32),
    .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES       (2),
    .CNT_W             (20),
    .RETRY_W           (4)
  ) dut (
    .refclk     (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fault      (fault),
    .lock_lost  (lock_lost),
    .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [8:0] v,
                      input string n);
    exp_t e;
    e.cyc  = c;
    e.vec  = v;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  logic [8:0] prev = 'x;

  always @(negedge clk) begin
    logic [8:0] vec;
    exp_t e;
    vec = {pll_rst, sys_rst, ready, fault, lock_lost, retry_count};
    if (vec !== prev) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected: cyc=%0d vec=%b, none required",
                 cyc, vec);
      end else begin
        e = q.pop_front();
        if (e.vec !== vec || e.cyc != cyc) begin
          bad++;
          $display("FAIL %s: cyc=%0d vec=%b, required cyc=%0d vec=%b",
                   e.name, cyc, vec, e.cyc, e.vec);
        end
      end
      prev = vec;
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL %s: no change by cyc=%0d vec=%b, required cyc=%0d vec=%b",
               e.name, cyc, vec, e.cyc, e.vec);
    end
  end

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    // nominal lock, loss of lock in RUN, relock
    push(1,  V_R, "reset_state");
    push(7,  V_W, "hold_4_cycles");
    push(27, V_U, "nominal_run");
    push(33, V_L, "lock_lost_pulse");
    push(34, V_R, "lock_lost_end");
    push(37, V_W, "rehold_4_cycles");
    push(51, V_U, "relock_run");
    at(3);   rst = 1'b0;
    at(16);  pll_locked = 1'b1;
    at(30);  pll_locked = 1'b0;
    at(40);  pll_locked = 1'b1;
    // glitchy lock aborts STABLE
    at(54);
    push(55, V_R, "glitch_reset");
    push(59, V_W, "glitch_wait");
    push(77, V_U, "glitch_run");
    rst = 1'b1; pll_locked = 1'b0;
    at(55);  rst = 1'b0;
    at(60);  pll_locked = 1'b1;
    at(65);  pll_locked = 1'b0;
    at(66);  pll_locked = 1'b1;
    // rst asserted during STABLE
    at(80);
    push(81,  V_R, "c_reset");
    push(85,  V_W, "c_wait");
    push(92,  V_R, "rst_in_stable");
    push(96,  V_W, "c_wait2");
    push(105, V_U, "c_run");
    rst = 1'b1; pll_locked = 1'b0;
    at(81);  rst = 1'b0;
    at(85);  pll_locked = 1'b1;
    at(91);  rst = 1'b1;
    at(92);  rst = 1'b0;
    // no lock ever -> FAULT, then rst out of FAULT
    at(108);
    push(109, V_R,  "d_reset");
    push(113, V_W,  "d_wait1");
    push(145, V_H1, "timeout_retry1");
    push(149, V_W1, "d_wait2");
    push(181, V_F,  "fault_entry");
    push(191, V_R,  "rst_in_fault");
    push(195, V_W,  "d_wait3");
    push(204, V_U,  "d_run");
    rst = 1'b1; pll_locked = 1'b0;
    at(109); rst = 1'b0;
    at(185); pll_locked = 1'b1;
    at(190); rst = 1'b1;
    at(191); rst = 1'b0;
    // lock seen on the final WAIT_LOCK cycle
    at(207);
    push(208, V_R, "e_reset");
    push(212, V_W, "e_wait");
    push(252, V_U, "lock_on_timeout");
    rst = 1'b1; pll_locked = 1'b0;
    at(208); rst = 1'b0;
    at(241); pll_locked = 1'b1;
    // drop seen on the final STABLE cycle
    at(255);
    push(256, V_R, "f_reset");
    push(260, V_W, "f_wait");
    push(280, V_U, "drop_on_stable_end");
    rst = 1'b1; pll_locked = 1'b0;
    at(256); rst = 1'b0;
    at(260); pll_locked = 1'b1;
    at(268); pll_locked = 1'b0;
    at(269); pll_locked = 1'b1;
    at(290);
    while (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s: still pending at cyc=%0d, required cyc=%0d vec=%b",
               q[0].name, cyc, q[0].cyc, q[0].vec);
      void'(q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
